// File: rtl/ttpu_pkg.sv
// ttpu_pkg: shared types and constants for the kernel sequencer slice.
//   seq_state_e : sequencer FSM states
//   ADDR_W      : weight address width
//   KSIZE_W     : kernel-size / step-counter width
//   TAG_*       : delay-line tag layout (bit 0 = accumulate, bit 1 = bias)
package ttpu_pkg;

    localparam int ADDR_W   = 16;
    localparam int KSIZE_W  = 8;
    localparam int TAG_W    = 2;
    localparam int TAG_ACC  = 0;
    localparam int TAG_BIAS = 1;

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        FETCH,
        DRAIN,
        BIAS,
        BWAIT,
        DONE
    } seq_state_e;

endpackage

// File: rtl/kernel_sequencer_lat_pipe.sv
// lat_pipe: fixed-depth delay line that replays a transfer tag DEPTH cycles
// after it was issued, matching the memory read latency.
//   clk, rst : clock, async active-high reset
//   flush    : synchronous clear of every in-flight tag
//   din      : tag of the transfer happening this cycle ('0 if none)
//   dout     : tag of the transfer issued DEPTH cycles ago
module lat_pipe #(
    parameter int DEPTH = 2,
    parameter int W     = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    logic [DEPTH-1:0][W-1:0] stage;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage <= '0;
        end else if (flush) begin
            stage <= '0;
        end else begin
            stage[0] <= din;
            for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
    end

    // stage[k] holds a tag issued k+1 cycles ago
    assign dout = stage[DEPTH-1];

endmodule

// File: rtl/kernel_sequencer.sv
// kernel_sequencer: sequences one convolution job -- pointer-bank reload,
// kernel_size weight fetches, latency drain, one bias fetch, done pulse.
//   start/abort/cfg_*  : job control and configuration (cfg sampled in IDLE)
//   busy/done/err      : job status (done, err are one-cycle pulses)
//   ptr_*              : pointer-bank control and latched configuration
//   mem_req/mem_gnt    : memory read handshake (transfer = req && gnt)
//   mac_clear/mac_acc_en/bias_load : MAC unit control, aligned to read data
//   stall_cycles       : cycles with mem_req && !mem_gnt
// Optional feature macro: SEQ_PERF_CNT_EN enables the stall counter;
// without it stall_cycles is tied to zero.
module kernel_sequencer
    import ttpu_pkg::*;
#(
    parameter int N_UNITS = 16,
    parameter int MEM_LAT = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                abort,
    input  logic [ADDR_W-1:0]   cfg_start_addr,
    input  logic [KSIZE_W-1:0]  cfg_kernel_size,
    input  logic [N_UNITS-1:0]  cfg_active_units,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic                ptr_init,
    output logic                ptr_step,
    output logic [ADDR_W-1:0]   ptr_start_addr,
    output logic [KSIZE_W-1:0]  ptr_kernel_size,
    output logic [N_UNITS-1:0]  ptr_active_units,
    output logic                mem_req,
    input  logic                mem_gnt,
    output logic                mac_clear,
    output logic                mac_acc_en,
    output logic                bias_load,
    output logic [15:0]         stall_cycles
);

    localparam logic [3:0] DRAIN_LAST = 4'(MEM_LAT - 1);

    seq_state_e         state, nstate;
    logic [KSIZE_W-1:0] step_cnt;
    logic [3:0]         drain_cnt;
    logic               err_q;
    logic [TAG_W-1:0]   xfer_tag, ret_tag;
    logic               start_ok, last_step, kill;

    assign start_ok = start && (cfg_kernel_size != '0) && (|cfg_active_units);
    // 9-bit compare so kernel_size 255 terminates before the counter wraps
    assign last_step = ({1'b0, step_cnt} + 9'd1) == {1'b0, ptr_kernel_size};
    assign kill = abort && (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= nstate;
    end

    always_comb begin
        nstate    = state;
        ptr_init  = 1'b0;
        ptr_step  = 1'b0;
        mem_req   = 1'b0;
        mac_clear = 1'b0;
        done      = 1'b0;
        xfer_tag  = '0;
        case (state)
            IDLE:  if (start_ok) nstate = INIT;
            INIT: begin
                ptr_init  = 1'b1;
                mac_clear = 1'b1;
                nstate    = FETCH;
            end
            FETCH: begin
                mem_req = 1'b1;
                if (mem_gnt) begin
                    ptr_step          = 1'b1;
                    xfer_tag[TAG_ACC] = 1'b1;
                    if (last_step) nstate = DRAIN;
                end
            end
            DRAIN: if (drain_cnt == DRAIN_LAST) nstate = BIAS;
            BIAS: begin
                mem_req = 1'b1;
                if (mem_gnt) begin
                    xfer_tag[TAG_BIAS] = 1'b1;
                    nstate             = BWAIT;
                end
            end
            BWAIT: if (bias_load) nstate = DONE;
            DONE: begin
                done   = 1'b1;
                nstate = IDLE;
            end
            default: nstate = IDLE;
        endcase
        // abort wins over a same-cycle grant: no step, no tag, no done
        if (kill) begin
            nstate   = IDLE;
            ptr_step = 1'b0;
            xfer_tag = '0;
            done     = 1'b0;
        end
    end

    assign busy = (state != IDLE);
    assign err  = err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_start_addr   <= '0;
            ptr_kernel_size  <= '0;
            ptr_active_units <= '0;
            step_cnt         <= '0;
            drain_cnt        <= '0;
            err_q            <= 1'b0;
        end else begin
            err_q <= (state == IDLE) && start && !start_ok;
            if (state == IDLE && start_ok) begin
                ptr_start_addr   <= cfg_start_addr;
                ptr_kernel_size  <= cfg_kernel_size;
                ptr_active_units <= cfg_active_units;
            end
            if (state == INIT)     step_cnt <= '0;
            else if (ptr_step)     step_cnt <= step_cnt + 1'b1;
            drain_cnt <= (state == DRAIN) ? drain_cnt + 1'b1 : 4'd0;
        end
    end

    lat_pipe #(.DEPTH(MEM_LAT), .W(TAG_W)) u_lat_pipe (
        .clk   (clk),
        .rst   (rst),
        .flush (kill),
        .din   (xfer_tag),
        .dout  (ret_tag)
    );

    assign mac_acc_en = ret_tag[TAG_ACC];
    assign bias_load  = ret_tag[TAG_BIAS];

`ifdef SEQ_PERF_CNT_EN
    logic [15:0] stall_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                         stall_q <= '0;
        else if (state == IDLE && start_ok)              stall_q <= '0;
        else if (mem_req && !mem_gnt && stall_q != 16'hFFFF) stall_q <= stall_q + 16'd1;
    end
    assign stall_cycles = stall_q;
`else
    assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_kernel_sequencer.sv
// tb_kernel_sequencer: randomized scoreboard bench for kernel_sequencer.
// Each job is turned into expected event times (per strobe) by a job-level
// model computed from the grant sequence; a monitor pops and compares them.
module tb_kernel_sequencer;

    localparam int N_UNITS = 16;
    localparam int MEM_LAT = 2;
    localparam int GN      = 4096;

    logic clk = 1'b0;
    logic rst, start, abort, mem_gnt;
    logic [15:0] cfg_start_addr;
    logic [7:0]  cfg_kernel_size;
    logic [N_UNITS-1:0] cfg_active_units;
    logic busy, done, err, ptr_init, ptr_step, mem_req, mac_clear, mac_acc_en, bias_load;
    logic [15:0] ptr_start_addr, stall_cycles;
    logic [7:0]  ptr_kernel_size;
    logic [N_UNITS-1:0] ptr_active_units;

    kernel_sequencer #(.N_UNITS(N_UNITS), .MEM_LAT(MEM_LAT)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .cfg_start_addr(cfg_start_addr), .cfg_kernel_size(cfg_kernel_size),
        .cfg_active_units(cfg_active_units), .busy(busy), .done(done), .err(err),
        .ptr_init(ptr_init), .ptr_step(ptr_step), .ptr_start_addr(ptr_start_addr),
        .ptr_kernel_size(ptr_kernel_size), .ptr_active_units(ptr_active_units),
        .mem_req(mem_req), .mem_gnt(mem_gnt), .mac_clear(mac_clear),
        .mac_acc_en(mac_acc_en), .bias_load(bias_load), .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0, bad = 0;
    int q[6][$];          // expected absolute cycles: init, step, acc, bias, done, err
    bit mon_en = 1'b0;
    int g[GN];

    function automatic string ev_name(input int k);
        case (k)
            0: return "ptr_init";
            1: return "ptr_step";
            2: return "mac_acc_en";
            3: return "bias_load";
            4: return "done";
            default: return "err";
        endcase
    endfunction

    task automatic check(input bit ok, input string nm, input longint act, input longint exp);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One job: model computes every strobe time from the grant sequence,
    // then the bench drives the job and finally checks leftovers/latches.
    // gmode: 0 grant always, 1 grant low every 2nd fetch cycle, 2 random.
    task automatic run_job(input int k, input logic [N_UNITS-1:0] mask,
                           input logic [15:0] addr, input int gmode, input int ab);
        int c0, t, n, st, tl, tb, last_busy, end_rel, rel;
        bit valid;
        valid = (k != 0) && (mask != '0);
        for (int i = 0; i < GN; i++) begin
            case (gmode)
                0:       g[i] = 1;
                1:       g[i] = (i < 2*k + 1) ? int'(i % 2 == 0) : 1;
                default: g[i] = int'($urandom_range(3, 0) != 0);
            endcase
        end
        tick();
        c0 = cyc;
        st = 0; tb = 0;
        if (!valid) begin
            q[5].push_back(c0 + 1);
            last_busy = 0;
            end_rel   = 4;
        end else begin
            if (ab < 0 || 1 < ab) q[0].push_back(c0 + 1);
            t = 2; n = 0;
            while (n < k && t < GN - 64) begin
                if (g[t] != 0) begin
                    if (ab < 0 || t < ab)            q[1].push_back(c0 + t);
                    if (ab < 0 || t + MEM_LAT <= ab) q[2].push_back(c0 + t + MEM_LAT);
                    n++;
                end else st++;
                t++;
            end
            tl = t - 1;
            t  = tl + 1 + MEM_LAT;
            while (g[t] == 0 && t < GN - 8) begin st++; t++; end
            tb = t;
            if (ab < 0) begin
                q[3].push_back(c0 + tb + MEM_LAT);
                q[4].push_back(c0 + tb + MEM_LAT + 1);
                last_busy = tb + MEM_LAT + 1;
                end_rel   = last_busy + 3;
            end else begin
                last_busy = ab;
                end_rel   = ab + MEM_LAT + 3;
            end
        end
        cfg_kernel_size  = 8'(k);
        cfg_active_units = mask;
        cfg_start_addr   = addr;
        start            = 1'b1;
        abort            = 1'b0;
        mem_gnt          = g[0][0];
        for (rel = 1; rel <= end_rel; rel++) begin
            tick();
            if (cyc - c0 != rel) check(0, "cycle_align", cyc - c0, rel);
            mem_gnt = (rel < GN) ? g[rel][0] : 1'b1;
            abort   = (rel == ab);
            if (rel <= last_busy) begin
                // start and cfg noise while busy must be ignored
                start            = $urandom_range(1, 0) != 0;
                cfg_kernel_size  = 8'($urandom);
                cfg_active_units = N_UNITS'($urandom);
                cfg_start_addr   = 16'($urandom);
            end else start = 1'b0;
            if (!valid && rel <= 2) check(busy == 1'b0, "err_busy", busy, 0);
        end
        abort = 1'b0;
        for (int e = 0; e < 6; e++) begin
            check(q[e].size() == 0, {ev_name(e), "_missing"}, q[e].size(), 0);
            q[e].delete();
        end
        check(busy == 1'b0, "busy_end", busy, 0);
        if (valid) begin
            check(ptr_kernel_size == 8'(k), "ptr_kernel_size", ptr_kernel_size, k);
            check(ptr_active_units == mask, "ptr_active_units", ptr_active_units, mask);
            check(ptr_start_addr == addr, "ptr_start_addr", ptr_start_addr, addr);
            if (ab < 0) begin
`ifdef SEQ_PERF_CNT_EN
                check(stall_cycles == 16'(st), "stall_cycles", stall_cycles, st);
`else
                check(stall_cycles == 16'd0, "stall_cycles", stall_cycles, 0);
`endif
            end
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; mem_gnt = 1'b0;
        cfg_start_addr = '0; cfg_kernel_size = '0; cfg_active_units = '0;

        fork
            forever begin
                @(negedge clk);
                if (mon_en && !rst) begin
                    logic [5:0] ev;
                    ev = {err, done, bias_load, mac_acc_en, ptr_step, ptr_init};
                    for (int e = 0; e < 6; e++) begin
                        if (ev[e]) begin
                            if (q[e].size() == 0) check(0, {ev_name(e), "_unexpected"}, cyc, -1);
                            else begin
                                int x;
                                x = q[e].pop_front();
                                check(cyc == x, ev_name(e), cyc, x);
                            end
                        end
                    end
                    if (ptr_init) check(mac_clear == 1'b1, "mac_clear", mac_clear, 1);
                end
            end
        join_none

        tick(); tick();
        check({busy, done, err, ptr_init, ptr_step, mem_req, mac_clear, mac_acc_en, bias_load} == '0,
              "reset_strobes", {busy, done, err, ptr_init, ptr_step, mem_req, mac_clear, mac_acc_en, bias_load}, 0);
        check({ptr_start_addr, ptr_kernel_size, ptr_active_units, stall_cycles} == '0,
              "reset_ptr", {ptr_start_addr, ptr_kernel_size}, 0);
        rst = 1'b0;
        mon_en = 1'b1;
        tick();

        run_job(4, 16'h000F, 16'h1234, 0, -1);     // reference timing
        run_job(3, 16'h00F0, 16'h0100, 1, -1);     // alternating grant
        run_job(0, 16'h000F, 16'h0200, 0, -1);     // zero kernel
        run_job(5, 16'h0000, 16'h0300, 0, -1);     // zero mask
        run_job(8, 16'hFFFF, 16'h0400, 0, 4);      // abort after 2nd step

        // async reset in FETCH: outputs must drop before the next edge
        mon_en = 1'b0;
        cfg_kernel_size = 8'd8; cfg_active_units = 16'h0003; cfg_start_addr = 16'hBEEF;
        start = 1'b1; mem_gnt = 1'b1;
        tick(); start = 1'b0;
        tick(); tick(); tick();
        #2 rst = 1'b1;
        #1;
        check({busy, ptr_step, mem_req, mac_acc_en, ptr_init, mac_clear, bias_load, done, err} == '0,
              "async_rst_strobes", {busy, ptr_step, mem_req, mac_acc_en}, 0);
        check({ptr_start_addr, ptr_kernel_size, ptr_active_units, stall_cycles} == '0,
              "async_rst_ptr", ptr_start_addr, 0);
        tick();
        rst = 1'b0;
        tick();
        mon_en = 1'b1;
        run_job(6, 16'h0101, 16'h0500, 2, -1);

        run_job(255, 16'h8001, 16'hFFFF, 0, -1);   // max kernel, no wrap

        for (int j = 0; j < 25; j++) begin
            int k, ab;
            logic [N_UNITS-1:0] m;
            k  = $urandom_range(40, 1);
            m  = N_UNITS'($urandom);
            if (m == '0) m = 1;
            if ($urandom_range(7, 0) == 0) begin
                if ($urandom_range(1, 0) != 0) k = 0; else m = '0;
            end
            ab = ($urandom_range(3, 0) == 0 && k > 0) ? 2 + int'($urandom_range(k - 1, 0)) : -1;
            run_job(k, m, 16'($urandom), 2, ab);
        end

        mon_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
